wb_stage: RTL and testbench

- Write-back end of the register-file interface; produces the write request that the decode stage's register file consumes.
- Holds the MEM/WB pipeline register and selects the write-back value using the RF_WSEL_* codes.
- Drives rf_we, rf_wR and rf_wD to the register file.
- Supplies WB-to-ID bypassed operands so a same-cycle write is visible to the instruction being decoded.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, write-back mux, WB-to-ID bypass, retire counter.
// Optional trace outputs are built when DEBUG_TRACE_EN is defined.
module wb_stage #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_pc4,
   input  logic [31:0]      in_alu_c,
   input  logic [31:0]      in_ext,
   input  logic [31:0]      in_rdo,
   input  logic [1:0]       in_rf_wsel,
   input  logic             in_rf_we,
   input  logic [4:0]       in_wR,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [31:0]      id_rD1,
   input  logic [31:0]      id_rD2,
   output logic             wb_valid,
   output logic [31:0]      wb_pc,
   output logic             rf_we,
   output logic [4:0]       rf_wR,
   output logic [31:0]      rf_wD,
   output logic [31:0]      fwd_rD1,
   output logic [31:0]      fwd_rD2,
   output logic [CNT_W-1:0] retired_cnt
`ifdef DEBUG_TRACE_EN
   ,
   output logic             debug_wb_have_inst,
   output logic [31:0]      debug_wb_pc,
   output logic             debug_wb_ena,
   output logic [4:0]       debug_wb_reg,
   output logic [31:0]      debug_wb_value
`endif
);

   localparam logic [1:0] RF_WSEL_ALU = 2'd0;
   localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
   localparam logic [1:0] RF_WSEL_EXT = 2'd2;
   localparam logic [1:0] RF_WSEL_RDO = 2'd3;

   logic             valid_q, valid_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc4_q, pc4_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      ext_q, ext_d;
   logic [31:0]      rdo_q, rdo_d;
   logic [1:0]       wsel_q, wsel_d;
   logic             we_q, we_d;
   logic [4:0]       wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Flush outranks stall; a flushed slot still loads data but is marked invalid.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      alu_d   = alu_q;
      ext_d   = ext_q;
      rdo_d   = rdo_q;
      wsel_d  = wsel_q;
      we_d    = we_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (valid_q && !stall) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (flush || !stall) begin
         valid_d = flush ? 1'b0 : in_valid;
         pc_d    = in_pc;
         pc4_d   = in_pc4;
         alu_d   = in_alu_c;
         ext_d   = in_ext;
         rdo_d   = in_rdo;
         wsel_d  = in_rf_wsel;
         we_d    = in_rf_we;
         wr_d    = in_wR;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         pc4_q   <= '0;
         alu_q   <= '0;
         ext_q   <= '0;
         rdo_q   <= '0;
         wsel_q  <= RF_WSEL_ALU;
         we_q    <= 1'b0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         alu_q   <= alu_d;
         ext_q   <= ext_d;
         rdo_q   <= rdo_d;
         wsel_q  <= wsel_d;
         we_q    <= we_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      rf_wD = '0;
      case (wsel_q)
         RF_WSEL_ALU: rf_wD = alu_q;
         RF_WSEL_PC4: rf_wD = pc4_q;
         RF_WSEL_EXT: rf_wD = ext_q;
         RF_WSEL_RDO: rf_wD = rdo_q;
         default:     rf_wD = '0;
      endcase
   end

   // x0 is never written, which also keeps rs==0 from ever bypassing.
   assign rf_we       = valid_q & we_q & (wr_q != 5'd0);
   assign rf_wR       = wr_q;
   assign wb_valid    = valid_q;
   assign wb_pc       = pc_q;
   assign retired_cnt = cnt_q;
   assign fwd_rD1     = (rf_we && (rf_wR == id_rs1)) ? rf_wD : id_rD1;
   assign fwd_rD2     = (rf_we && (rf_wR == id_rs2)) ? rf_wD : id_rD2;

`ifdef DEBUG_TRACE_EN
   assign debug_wb_have_inst = valid_q & ~stall;
   assign debug_wb_pc        = pc_q;
   assign debug_wb_ena       = rf_we & ~stall;
   assign debug_wb_reg       = wr_q;
   assign debug_wb_value     = rf_wD;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; a second instance with CNT_W=4 checks counter wrap.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, stall, flush, in_rf_we;
   logic [31:0] in_pc, in_pc4, in_alu_c, in_ext, in_rdo, id_rD1, id_rD2;
   logic [1:0]  in_rf_wsel;
   logic [4:0]  in_wR, id_rs1, id_rs2;

   logic        wb_valid, rf_we, wb_valid4, rf_we4;
   logic [31:0] wb_pc, rf_wD, fwd_rD1, fwd_rD2, wb_pc4, rf_wD4, fwd4_1, fwd4_2;
   logic [4:0]  rf_wR, rf_wR4;
   logic [31:0] retired_cnt;
   logic [3:0]  retired_cnt4;
`ifdef DEBUG_TRACE_EN
   logic        d_have, d_ena, d_have4, d_ena4;
   logic [31:0] d_pc, d_val, d_pc4, d_val4;
   logic [4:0]  d_reg, d_reg4;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_stage #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_pc(in_pc), .in_pc4(in_pc4), .in_alu_c(in_alu_c), .in_ext(in_ext), .in_rdo(in_rdo),
      .in_rf_wsel(in_rf_wsel), .in_rf_we(in_rf_we), .in_wR(in_wR),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rD1(id_rD1), .id_rD2(id_rD2),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD),
      .fwd_rD1(fwd_rD1), .fwd_rD2(fwd_rD2), .retired_cnt(retired_cnt)
`ifdef DEBUG_TRACE_EN
      , .debug_wb_have_inst(d_have), .debug_wb_pc(d_pc), .debug_wb_ena(d_ena),
      .debug_wb_reg(d_reg), .debug_wb_value(d_val)
`endif
   );

   wb_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
      .in_pc(in_pc), .in_pc4(in_pc4), .in_alu_c(in_alu_c), .in_ext(in_ext), .in_rdo(in_rdo),
      .in_rf_wsel(in_rf_wsel), .in_rf_we(in_rf_we), .in_wR(in_wR),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rD1(id_rD1), .id_rD2(id_rD2),
      .wb_valid(wb_valid4), .wb_pc(wb_pc4), .rf_we(rf_we4), .rf_wR(rf_wR4), .rf_wD(rf_wD4),
      .fwd_rD1(fwd4_1), .fwd_rD2(fwd4_2), .retired_cnt(retired_cnt4)
`ifdef DEBUG_TRACE_EN
      , .debug_wb_have_inst(d_have4), .debug_wb_pc(d_pc4), .debug_wb_ena(d_ena4),
      .debug_wb_reg(d_reg4), .debug_wb_value(d_val4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic [1:0] ws, input logic we, input logic [4:0] wr,
                       input logic [31:0] alu);
      in_valid = v; in_rf_wsel = ws; in_rf_we = we; in_wR = wr; in_alu_c = alu;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; in_rf_we = 1'b0;
      in_pc = 32'h100; in_pc4 = 32'h22; in_alu_c = 32'h0; in_ext = 32'h33; in_rdo = 32'h44;
      in_rf_wsel = 2'd0; in_wR = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      id_rD1 = 32'h1234; id_rD2 = 32'h5678;

      // 1. reset then idle
      tick(); tick();
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_wD", rf_wD, 32'd0);
      chk("rst_cnt", retired_cnt, 32'd0);
      chk("rst_fwd1", fwd_rD1, 32'h1234);
      chk("rst_fwd2", fwd_rD2, 32'h5678);
      rst_n = 1'b1;

      // 2. write-back mux
      send(1'b1, 2'd0, 1'b1, 5'd5, 32'h11);
      tick();
      chk("mux_alu", rf_wD, 32'h11);
      chk("mux_we", {31'd0, rf_we}, 32'd1);
      chk("mux_wR", {27'd0, rf_wR}, 32'd5);
      chk("mux_pc", wb_pc, 32'h100);
      in_rf_wsel = 2'd1; tick();
      chk("mux_pc4", rf_wD, 32'h22);
      in_rf_wsel = 2'd2; tick();
      chk("mux_ext", rf_wD, 32'h33);
      in_rf_wsel = 2'd3; tick();
      chk("mux_rdo", rf_wD, 32'h44);
      chk("mux_cnt3", retired_cnt, 32'd3);
      in_valid = 1'b0; tick();
      chk("mux_cnt4", retired_cnt, 32'd4);
      chk("idle_we", {31'd0, rf_we}, 32'd0);

      // 3. x0 suppression
      send(1'b1, 2'd0, 1'b1, 5'd0, 32'hDEAD);
      id_rs1 = 5'd0; id_rD1 = 32'h55;
      tick();
      chk("x0_we", {31'd0, rf_we}, 32'd0);
      chk("x0_wD", rf_wD, 32'hDEAD);
      chk("x0_fwd1", fwd_rD1, 32'h55);

      // 4. bypass
      send(1'b1, 2'd0, 1'b1, 5'd7, 32'hCAFE);
      tick();
      id_rs1 = 5'd7; id_rs2 = 5'd8; id_rD1 = 32'h1; id_rD2 = 32'h2;
      #1;
      chk("byp_fwd1", fwd_rD1, 32'hCAFE);
      chk("byp_fwd2", fwd_rD2, 32'h2);
      chk("byp_cnt", retired_cnt, 32'd5);
      id_rs2 = 5'd7; #1;
      chk("byp_fwd2_hit", fwd_rD2, 32'hCAFE);

      // 5. stall holds contents and counter, flush beats stall
      stall = 1'b1;
      send(1'b1, 2'd0, 1'b1, 5'd9, 32'hBEEF);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_wR", {27'd0, rf_wR}, 32'd7);
         chk("stall_wD", rf_wD, 32'hCAFE);
         chk("stall_valid", {31'd0, wb_valid}, 32'd1);
         chk("stall_cnt", retired_cnt, 32'd5);
      end
      flush = 1'b1; tick();
      chk("flush_valid", {31'd0, wb_valid}, 32'd0);
      chk("flush_we", {31'd0, rf_we}, 32'd0);
      chk("flush_wR", {27'd0, rf_wR}, 32'd9);
      chk("flush_cnt", retired_cnt, 32'd5);
      flush = 1'b0; stall = 1'b0;

      // reset during stall drops the pending instruction
      send(1'b1, 2'd0, 1'b1, 5'd3, 32'h77);
      tick();
      chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
      stall = 1'b1; rst_n = 1'b0; tick();
      chk("rst_stall_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_stall_we", {31'd0, rf_we}, 32'd0);
      chk("rst_stall_cnt", retired_cnt, 32'd0);
      rst_n = 1'b1; stall = 1'b0;

      // 6. counter wrap: 17 retirements
      send(1'b1, 2'd0, 1'b0, 5'd4, 32'h1);
      for (int i = 0; i < 17; i++) tick();
      in_valid = 1'b0; tick();
      chk("wrap_cnt4", {28'd0, retired_cnt4}, 32'd1);
      chk("wrap_cnt32", retired_cnt, 32'd17);
      chk("wrap_we0", {31'd0, rf_we}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
